avalon_byte_txn_master: RTL
===========================

// Module: avalon_byte_txn_master
// PURPOSE
//  Host-side initiator for the byte-stream Avalon-MM bridge. Turns one 32-bit read or write
//  command into a framed transaction byte stream (drives in_bytes_stream) and decodes the
//  framed response byte stream (from out_bytes_stream) into read data or write status.
//  Sits between a command source (UART/SPI host logic or a test sequencer) and the bridge.
// PARAMETERS
//  TIMEOUT_CYCLES  65535  cycles allowed from last TX byte to response complete; 0 disables
// PORTS
//  clk_clk               in   1   system clock
//  reset_reset_n         in   1   async active-low reset
//  cmd_valid             in   1   command request
//  cmd_ready             out  1   command accepted when cmd_valid & cmd_ready
//  cmd_write             in   1   1 = write, 0 = read
//  cmd_addr              in   32  byte address
//  cmd_wdata             in   32  write data (ignored for read)
//  rsp_valid             out  1   one-cycle pulse: transaction finished
//  rsp_rdata             out  32  read data (0 for writes and errors)
//  rsp_error             out  1   malformed response or timeout, valid with rsp_valid
//  busy                  out  1   high from cmd accept until rsp_valid
//  tx_bytes_stream_valid out  1   Avalon-ST source to bridge in_bytes_stream
//  tx_bytes_stream_ready in   1
//  tx_bytes_stream_data  out  8
//  rx_bytes_stream_valid in   1   Avalon-ST sink from bridge out_bytes_stream
//  rx_bytes_stream_ready out  1
//  rx_bytes_stream_data  in   8
// BEHAVIOUR
//  Reset: all outputs 0 except rx_bytes_stream_ready=1; FSM=IDLE. Reset mid-transfer aborts, no rsp.
//  Avalon-ST ready latency 0; beat transfers on valid&ready; tx data/valid held while !ready.
//  Framing: 0x7A (SOP) precedes payload byte 0; 0x7B (EOP) precedes last payload byte.
//   Payload byte in 0x7A..0x7D sent as 0x7D then byte^0x20 (two beats). Markers never escaped.
//  Write payload (12B): 04 00 00 04, addr[31:24..7:0], wdata[7:0..31:24] (LSB first).
//  Read payload (8B):   14 00 00 04, addr big-endian.
//  FSM: IDLE -> (cmd accept) TX -> RX_WAIT -> RSP -> IDLE.
//   IDLE: cmd_ready=1; capture cmd_* on accept; tx_valid rises next cycle.
//   TX: walk payload index 0..N-1, inserting SOP/EOP/escape beats; after last beat -> RX_WAIT,
//    timeout counter cleared.
//   RX_WAIT: decode rx: 0x7A starts packet (clears byte count), 0x7B flags next byte last,
//    0x7D un-escapes next byte, 0x7C plus following byte discarded (channel).
//    Write: expect 4 bytes 84 00 00 04; read: expect 4 bytes, assembled LSB first.
//    Packet end (byte after EOP) -> RSP. Error if byte count != 4, write bytes mismatch,
//    data byte before SOP, or counter reaches TIMEOUT_CYCLES.
//   RSP: rsp_valid=1 one cycle, rsp_rdata/rsp_error held until next cmd accept -> IDLE.
//  rx_bytes_stream_ready always 1 (never stalls bridge); rx bytes outside RX_WAIT discarded.
//  Second SOP inside RX_WAIT restarts decode (count=0). Timeout counter saturates, no wrap.
//  Only one transaction in flight; cmd_ready=0 outside IDLE.
// TESTING
//  Write addr 0x00001000 data 0xDEADBEEF, tx_ready=1 -> tx bytes 7A 04 00 00 04 00 00 10 00
//   EF BE AD 7B DE; rx 7A 84 00 00 7B 04 -> rsp_valid, rsp_error=0.
//  Write data 0x0000007B -> payload byte 7B sent as 7D 5B; 15 tx beats total.
//  Read addr 0x20 -> tx 7A 14 00 00 04 00 00 00 7B 20; rx 7A 78 56 34 7B 12
//   -> rsp_rdata=0x12345678, rsp_error=0.
//  Read response with escaped byte: rx 7A 7D 5A 00 00 7B 00 -> rsp_rdata=0x0000007A.
//  Random tx_ready backpressure (50%) -> byte sequence identical to no-stall case, data stable
//   while stalled.
//  TIMEOUT_CYCLES=100, no rx -> rsp_valid with rsp_error=1 exactly 100 cycles after last tx
//   beat; reset asserted mid-TX -> tx_valid=0 immediately, cmd_ready=1 after release.

Source files
------------

// File: rtl/avalon_byte_txn_master.sv
// Host-side initiator for the byte-stream Avalon-MM bridge: frames one 32-bit read/write
// command into a transaction byte stream and decodes the framed response stream.
module avalon_byte_txn_master #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        tx_bytes_stream_valid,
    input  logic        tx_bytes_stream_ready,
    output logic [7:0]  tx_bytes_stream_data,
    input  logic        rx_bytes_stream_valid,
    output logic        rx_bytes_stream_ready,
    input  logic [7:0]  rx_bytes_stream_data
);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX_WAIT, S_RSP} state_t;

    localparam logic [7:0] SOP  = 8'h7A;
    localparam logic [7:0] EOP  = 8'h7B;
    localparam logic [7:0] CHAN = 8'h7C;
    localparam logic [7:0] ESC  = 8'h7D;

    function automatic logic is_special(input logic [7:0] b);
        return (b >= SOP) && (b <= ESC);
    endfunction

    function automatic logic [7:0] pay_byte(input logic wr, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] i);
        case (i)
            4'd0:    pay_byte = wr ? 8'h04 : 8'h14;
            4'd3:    pay_byte = 8'h04;
            4'd4:    pay_byte = a[31:24];
            4'd5:    pay_byte = a[23:16];
            4'd6:    pay_byte = a[15:8];
            4'd7:    pay_byte = a[7:0];
            4'd8:    pay_byte = d[7:0];
            4'd9:    pay_byte = d[15:8];
            4'd10:   pay_byte = d[23:16];
            4'd11:   pay_byte = d[31:24];
            default: pay_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] wr_rsp_byte(input logic [1:0] i);
        case (i)
            2'd0:    wr_rsp_byte = 8'h84;
            2'd3:    wr_rsp_byte = 8'h04;
            default: wr_rsp_byte = 8'h00;
        endcase
    endfunction

    state_t      state_q;
    logic        wr_q, cmd_ready_q, busy_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  idx_q, idx_d;
    logic        mark_q, mark_d, esc_q, esc_d;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rsp_valid_q, rsp_error_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] timer_q;
    logic        in_pkt_q, last_q, rx_esc_q, chan_q, mism_q, mism_d, nosop_q;
    logic [2:0]  cnt_q, cnt_inc;
    logic [31:0] acc_q, acc_d;

    logic [3:0]  last_idx;
    logic [7:0]  cur_byte, nxt_byte, rx_b;
    logic        tx_fire, tx_last, rx_fire, rx_data_beat, rx_done, rx_err, tmo_hit;

    // Transmit walker: the pointer (idx, mark sent, escape sent) names the beat on the bus.
    always_comb begin
        last_idx = wr_q ? 4'd11 : 4'd7;
        cur_byte = pay_byte(wr_q, addr_q, wdata_q, idx_q);
        tx_fire  = tx_valid_q && tx_bytes_stream_ready;
        tx_last  = 1'b0;
        idx_d    = idx_q;
        mark_d   = mark_q;
        esc_d    = esc_q;
        if (((idx_q == 4'd0) || (idx_q == last_idx)) && !mark_q) begin
            mark_d = 1'b1;
        end else if (is_special(cur_byte) && !esc_q) begin
            esc_d = 1'b1;
        end else begin
            tx_last = (idx_q == last_idx);
            idx_d   = idx_q + 4'd1;
            mark_d  = 1'b0;
            esc_d   = 1'b0;
        end
        nxt_byte = pay_byte(wr_q, addr_q, wdata_q, idx_d);
        if (((idx_d == 4'd0) || (idx_d == last_idx)) && !mark_d)
            tx_data_d = (idx_d == 4'd0) ? SOP : EOP;
        else if (is_special(nxt_byte) && !esc_d)
            tx_data_d = ESC;
        else if (esc_d)
            tx_data_d = nxt_byte ^ 8'h20;
        else
            tx_data_d = nxt_byte;
    end

    // Receive decoder: a data beat is any non-control byte not swallowed as a channel number.
    always_comb begin
        rx_fire      = rx_bytes_stream_valid && (state_q == S_RX_WAIT);
        rx_b         = rx_esc_q ? (rx_bytes_stream_data ^ 8'h20) : rx_bytes_stream_data;
        rx_data_beat = rx_fire && !chan_q && !is_special(rx_bytes_stream_data);
        cnt_inc      = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
        acc_d        = acc_q;
        mism_d       = mism_q;
        if (rx_data_beat && in_pkt_q && (cnt_q < 3'd4)) begin
            acc_d[{cnt_q[1:0], 3'b000} +: 8] = rx_b;
            if (wr_q && (rx_b != wr_rsp_byte(cnt_q[1:0])))
                mism_d = 1'b1;
        end
        rx_done = rx_data_beat && in_pkt_q && last_q;
        rx_err  = mism_d || (cnt_inc != 3'd4) || nosop_q;
        tmo_hit = (TIMEOUT_CYCLES != 0) && (timer_q >= 32'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            mark_q      <= 1'b0;
            esc_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            timer_q     <= '0;
            in_pkt_q    <= 1'b0;
            last_q      <= 1'b0;
            rx_esc_q    <= 1'b0;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            mism_q      <= 1'b0;
            nosop_q     <= 1'b0;
            acc_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= S_TX;
                        wr_q        <= cmd_write;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b0;
                        idx_q       <= '0;
                        mark_q      <= 1'b0;
                        esc_q       <= 1'b0;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= SOP;
                    end
                end
                S_TX: begin
                    if (tx_fire) begin
                        if (tx_last) begin
                            state_q    <= S_RX_WAIT;
                            tx_valid_q <= 1'b0;
                            timer_q    <= '0;
                            in_pkt_q   <= 1'b0;
                            last_q     <= 1'b0;
                            rx_esc_q   <= 1'b0;
                            chan_q     <= 1'b0;
                            cnt_q      <= '0;
                            mism_q     <= 1'b0;
                            nosop_q    <= 1'b0;
                            acc_q      <= '0;
                        end else begin
                            idx_q     <= idx_d;
                            mark_q    <= mark_d;
                            esc_q     <= esc_d;
                            tx_data_q <= tx_data_d;
                        end
                    end
                end
                S_RX_WAIT: begin
                    if (timer_q != '1)
                        timer_q <= timer_q + 32'd1;
                    if (rx_fire) begin
                        if (chan_q) begin
                            chan_q <= 1'b0;
                        end else begin
                            case (rx_bytes_stream_data)
                                SOP: begin
                                    in_pkt_q <= 1'b1;
                                    cnt_q    <= '0;
                                    last_q   <= 1'b0;
                                    rx_esc_q <= 1'b0;
                                    mism_q   <= 1'b0;
                                    acc_q    <= '0;
                                end
                                EOP:  last_q   <= 1'b1;
                                CHAN: chan_q   <= 1'b1;
                                ESC:  rx_esc_q <= 1'b1;
                                default: begin
                                    rx_esc_q <= 1'b0;
                                    if (!in_pkt_q) begin
                                        nosop_q <= 1'b1;
                                    end else begin
                                        cnt_q  <= cnt_inc;
                                        acc_q  <= acc_d;
                                        mism_q <= mism_d;
                                    end
                                end
                            endcase
                        end
                    end
                    if (rx_done) begin
                        state_q     <= S_RSP;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= rx_err;
                        rsp_rdata_q <= (!wr_q && !rx_err) ? acc_d : 32'd0;
                    end else if (tmo_hit) begin
                        state_q     <= S_RSP;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                S_RSP: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready             = cmd_ready_q;
    assign busy                  = busy_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_rdata             = rsp_rdata_q;
    assign rsp_error             = rsp_error_q;
    assign tx_bytes_stream_valid = tx_valid_q;
    assign tx_bytes_stream_data  = tx_data_q;
    assign rx_bytes_stream_ready = 1'b1;

endmodule
